// File: rtl/tcm_pkg.sv
// Shared types and constants for the TCM data-port adapter and its response buffer.
package tcm_pkg;

  localparam int TCM_TAG_W           = 11;
  localparam int TCM_RESP_FIFO_DEPTH = 4;
  localparam int TCM_FIFO_PTR_W      = $clog2(TCM_RESP_FIFO_DEPTH);
  localparam int TCM_FIFO_CNT_W      = $clog2(TCM_RESP_FIFO_DEPTH + 1);

  // One response as seen by the requester.
  typedef struct packed {
    logic [31:0]          data;
    logic [TCM_TAG_W-1:0] tag;
    logic                 error;
  } tcm_resp_t;

  // Request accepted last cycle, waiting for the RAM read data.
  typedef struct packed {
    logic                 valid;
    logic [TCM_TAG_W-1:0] tag;
    logic                 upper;
    logic                 write;
    logic                 error;
  } tcm_inflight_t;

  // Picks the addressed 32-bit half of a 64-bit RAM word.
  function automatic logic [31:0] tcm_select_word(input logic [63:0] dword, input logic upper);
    return upper ? dword[63:32] : dword[31:0];
  endfunction

endpackage

// File: rtl/tcm_resp_fifo.sv
// Small response FIFO with registered storage, wrapping pointers and an occupancy count.
module tcm_resp_fifo
  import tcm_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  tcm_resp_t                 push_data_i,
  input  logic                      pop_i,
  output tcm_resp_t                 head_o,
  output logic                      valid_o,
  output logic [TCM_FIFO_CNT_W-1:0] count_o
);

  localparam logic [TCM_FIFO_CNT_W-1:0] FULL_COUNT = TCM_FIFO_CNT_W'(TCM_RESP_FIFO_DEPTH);

  tcm_resp_t                 mem_q [TCM_RESP_FIFO_DEPTH];
  logic [TCM_FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TCM_FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TCM_FIFO_CNT_W-1:0] count_q, count_d;
  logic                      do_push;
  logic                      do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != FULL_COUNT);

  // Next pointers and count; a simultaneous push and pop leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + TCM_FIFO_PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + TCM_FIFO_PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + TCM_FIFO_CNT_W'(1);
      2'b01:   count_d = count_q - TCM_FIFO_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and storage registers; reset drops every queued response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < TCM_RESP_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/tcm_dport_adapter.sv
// Adapts a 32-bit tagged request/response data port onto a 64-bit single-cycle-latency TCM RAM port.
module tcm_dport_adapter
  import tcm_pkg::*;
#(
  parameter  int TCM_MEM_DEPTH = 16,
  localparam int ADDR_W        = $clog2(TCM_MEM_DEPTH * 1024 / 8)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          mem_data_wr_i,
  input  logic                 mem_rd_i,
  input  logic [3:0]           mem_wr_i,
  input  logic [TCM_TAG_W-1:0] mem_req_tag_i,
  output logic                 mem_accept_o,
  output logic                 mem_ack_o,
  output logic [31:0]          mem_data_rd_o,
  output logic [TCM_TAG_W-1:0] mem_resp_tag_o,
  output logic                 mem_error_o,
  input  logic                 mem_resp_accept_i,
  output logic [ADDR_W-1:0]    ram_addr_o,
  output logic [63:0]          ram_data_wr_o,
  output logic [7:0]           ram_wr_o,
  input  logic [63:0]          ram_data_rd_i
);

  localparam logic [TCM_FIFO_CNT_W:0] ACCEPT_LIMIT = (TCM_FIFO_CNT_W + 1)'(TCM_RESP_FIFO_DEPTH);

  tcm_inflight_t             inflight_q, inflight_d;
  tcm_resp_t                 push_data;
  tcm_resp_t                 head;
  logic                      fifo_valid;
  logic [TCM_FIFO_CNT_W-1:0] fifo_count;
  logic [TCM_FIFO_CNT_W:0]   occupancy;
  logic                      req_wr;
  logic                      req;
  logic                      out_of_range;
  logic                      handshake;
  logic                      addr_unused;

  // Byte offset within a 32-bit word has no meaning on this port.
  assign addr_unused = ^mem_addr_i[1:0];

  assign req_wr       = |mem_wr_i;
  assign req          = mem_rd_i | req_wr;
  assign out_of_range = |mem_addr_i[31:ADDR_W+3];

  // Every accepted request owns a FIFO slot from acceptance until it is popped.
  assign occupancy    = (TCM_FIFO_CNT_W + 1)'(fifo_count) + (TCM_FIFO_CNT_W + 1)'(inflight_q.valid);
  assign mem_accept_o = (occupancy < ACCEPT_LIMIT);
  assign handshake    = req & mem_accept_o;

  assign ram_addr_o    = mem_addr_i[ADDR_W+2:3];
  assign ram_data_wr_o = {mem_data_wr_i, mem_data_wr_i};
  assign ram_wr_o      = (rst_i && handshake && req_wr && !out_of_range)
                         ? (mem_addr_i[2] ? {mem_wr_i, 4'h0} : {4'h0, mem_wr_i})
                         : 8'h00;

  // Captures what the response needs once the RAM data arrives next cycle.
  always_comb begin
    inflight_d       = '0;
    inflight_d.valid = handshake;
    if (handshake) begin
      inflight_d.tag   = mem_req_tag_i;
      inflight_d.upper = mem_addr_i[2];
      inflight_d.write = req_wr;
      inflight_d.error = out_of_range;
    end
  end

  // Inflight register; reset abandons a request whose data is still in the RAM.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // Response word: only in-range reads carry RAM data.
  always_comb begin
    push_data       = '0;
    push_data.tag   = inflight_q.tag;
    push_data.error = inflight_q.error;
    if (!inflight_q.write && !inflight_q.error) begin
      push_data.data = tcm_select_word(ram_data_rd_i, inflight_q.upper);
    end
  end

  tcm_resp_fifo u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight_q.valid),
    .push_data_i (push_data),
    .pop_i       (mem_ack_o & mem_resp_accept_i),
    .head_o      (head),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign mem_ack_o      = fifo_valid;
  assign mem_data_rd_o  = fifo_valid ? head.data  : 32'h0;
  assign mem_resp_tag_o = fifo_valid ? head.tag   : '0;
  assign mem_error_o    = fifo_valid ? head.error : 1'b0;

endmodule

// File: tb/tb_tcm_dport_adapter.sv
// Self-checking bench for tcm_dport_adapter: a queue-based response model plus directed scenarios.
module tb_tcm_dport_adapter;
  import tcm_pkg::*;

  localparam int ADDR_W = 11;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_wr_i = '0;
  logic        mem_rd_i = 1'b0;
  logic [3:0]  mem_wr_i = '0;
  logic [10:0] mem_req_tag_i = '0;
  logic        mem_accept_o;
  logic        mem_ack_o;
  logic [31:0] mem_data_rd_o;
  logic [10:0] mem_resp_tag_o;
  logic        mem_error_o;
  logic        mem_resp_accept_i = 1'b1;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [63:0] ram_data_wr_o;
  logic [7:0]  ram_wr_o;
  logic [63:0] ram_data_rd_i = '0;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk_i = ~clk_i;

  tcm_dport_adapter #(.TCM_MEM_DEPTH(16)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .mem_addr_i        (mem_addr_i),
    .mem_data_wr_i     (mem_data_wr_i),
    .mem_rd_i          (mem_rd_i),
    .mem_wr_i          (mem_wr_i),
    .mem_req_tag_i     (mem_req_tag_i),
    .mem_accept_o      (mem_accept_o),
    .mem_ack_o         (mem_ack_o),
    .mem_data_rd_o     (mem_data_rd_o),
    .mem_resp_tag_o    (mem_resp_tag_o),
    .mem_error_o       (mem_error_o),
    .mem_resp_accept_i (mem_resp_accept_i),
    .ram_addr_o        (ram_addr_o),
    .ram_data_wr_o     (ram_data_wr_o),
    .ram_wr_o          (ram_wr_o),
    .ram_data_rd_i     (ram_data_rd_i)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // 64-bit RAM with one cycle of read latency and byte write enables.
  logic [63:0] ramArray [2048];
  logic [63:0] merged;
  initial for (int i = 0; i < 2048; i++) ramArray[i] = '0;
  always @(posedge clk_i) begin
    merged = ramArray[ram_addr_o];
    for (int b = 0; b < 8; b++) begin
      if (ram_wr_o[b]) merged[b*8 +: 8] = ram_data_wr_o[b*8 +: 8];
    end
    ram_data_rd_i <= ramArray[ram_addr_o];
    ramArray[ram_addr_o] <= merged;
  end

  // Reference model: 32-bit word memory plus a queue of owed responses with earliest ack cycle.
  typedef struct {
    logic [31:0] data;
    logic [10:0] tag;
    logic        error;
    int          ready;
  } expResp_t;

  logic [31:0] refMem [int unsigned];
  expResp_t    expQ[$];
  int          cyc = 0;

  logic        mReq, mWr, mInRange, mAccept, mAck;
  logic [7:0]  mRamWr;
  logic [31:0] mWord;
  int unsigned mKey;
  expResp_t    mEntry;

  // Compare process: outputs must equal the model on every cycle.
  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      checkOutput("rst_ack", 64'(mem_ack_o), 64'd0);
      checkOutput("rst_accept", 64'(mem_accept_o), 64'd1);
      checkOutput("rst_data", 64'(mem_data_rd_o), 64'd0);
      checkOutput("rst_tag", 64'(mem_resp_tag_o), 64'd0);
      checkOutput("rst_err", 64'(mem_error_o), 64'd0);
      checkOutput("rst_ram_wr", 64'(ram_wr_o), 64'd0);
      expQ.delete();
    end else begin
      mWr      = (mem_wr_i != 4'h0);
      mReq     = mem_rd_i || mWr;
      mInRange = (mem_addr_i[31:ADDR_W+3] == '0);
      mAccept  = (expQ.size() < TCM_RESP_FIFO_DEPTH);
      mAck     = (expQ.size() > 0) && (expQ[0].ready <= cyc);
      checkOutput("accept", 64'(mem_accept_o), 64'(mAccept));
      checkOutput("ack", 64'(mem_ack_o), 64'(mAck));
      if (mAck) begin
        checkOutput("rdata", 64'(mem_data_rd_o), 64'(expQ[0].data));
        checkOutput("rtag", 64'(mem_resp_tag_o), 64'(expQ[0].tag));
        checkOutput("rerr", 64'(mem_error_o), 64'(expQ[0].error));
      end
      checkOutput("ram_addr", 64'(ram_addr_o), 64'(mem_addr_i[ADDR_W+2:3]));
      mRamWr = 8'h00;
      if (mReq && mAccept && mWr && mInRange) begin
        mRamWr = mem_addr_i[2] ? {mem_wr_i, 4'h0} : {4'h0, mem_wr_i};
      end
      checkOutput("ram_wr", 64'(ram_wr_o), 64'(mRamWr));
      if (mWr) checkOutput("ram_data_wr", ram_data_wr_o, {mem_data_wr_i, mem_data_wr_i});
      if (mAck && mem_resp_accept_i) void'(expQ.pop_front());
      if (mReq && mAccept) begin
        mKey   = mem_addr_i[31:2];
        mWord  = refMem.exists(mKey) ? refMem[mKey] : 32'h0;
        mEntry.tag   = mem_req_tag_i;
        mEntry.ready = cyc + 2;
        mEntry.error = !mInRange;
        mEntry.data  = 32'h0;
        if (mInRange && mWr) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_wr_i[b]) mWord[b*8 +: 8] = mem_data_wr_i[b*8 +: 8];
          end
          refMem[mKey] = mWord;
        end else if (mInRange) begin
          mEntry.data = mWord;
        end
        expQ.push_back(mEntry);
      end
    end
  end

  task automatic applyStimulus(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [10:0] tag);
    mem_rd_i      = rd;
    mem_wr_i      = wr;
    mem_addr_i    = addr;
    mem_data_wr_i = data;
    mem_req_tag_i = tag;
  endtask

  // One isolated request with the response sampled at the minimum-latency ack cycle.
  task automatic doTxn(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [10:0] tag,
                       output logic [7:0] ramWr, output logic [10:0] ramAddr,
                       output logic ack, output logic [31:0] rdata,
                       output logic [10:0] rtag, output logic err);
    @(posedge clk_i); #1;
    applyStimulus(rd, wr, addr, data, tag);
    @(negedge clk_i);
    ramWr   = ram_wr_o;
    ramAddr = ram_addr_o;
    @(posedge clk_i); #1;
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    ack   = mem_ack_o;
    rdata = mem_data_rd_o;
    rtag  = mem_resp_tag_o;
    err   = mem_error_o;
  endtask

  logic [7:0]  tRamWr;
  logic [10:0] tRamAddr;
  logic        tAck, tErr;
  logic [31:0] tData;
  logic [10:0] tTag;
  int          idx, stallAcc, accCnt, ackCnt;
  logic [10:0] got[$];

  initial begin
    // Reset and release
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("init_accept", 64'(mem_accept_o), 64'd1);
    checkOutput("init_ack", 64'(mem_ack_o), 64'd0);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);

    // Upper-half full write
    doTxn(1'b0, 4'hF, 32'h0000_0104, 32'h1122_3344, 11'h001, tRamWr, tRamAddr, tAck, tData, tTag, tErr);
    checkOutput("wr_ram_wr", 64'(tRamWr), 64'hF0);
    checkOutput("wr_ram_addr", 64'(tRamAddr), 64'h20);
    checkOutput("wr_ack", 64'(tAck), 64'd1);
    checkOutput("wr_data", 64'(tData), 64'd0);
    checkOutput("wr_err", 64'(tErr), 64'd0);

    // Read back the upper half
    doTxn(1'b1, 4'h0, 32'h0000_0104, 32'h0, 11'h02A, tRamWr, tRamAddr, tAck, tData, tTag, tErr);
    checkOutput("rd_ram_wr", 64'(tRamWr), 64'h00);
    checkOutput("rd_ack", 64'(tAck), 64'd1);
    checkOutput("rd_data", 64'(tData), 64'h1122_3344);
    checkOutput("rd_tag", 64'(tTag), 64'h02A);

    // Partial lower-half write then read
    doTxn(1'b0, 4'h3, 32'h0000_0100, 32'hCAFE_BEEF, 11'h003, tRamWr, tRamAddr, tAck, tData, tTag, tErr);
    checkOutput("lo_ram_wr", 64'(tRamWr), 64'h03);
    doTxn(1'b1, 4'h0, 32'h0000_0100, 32'h0, 11'h004, tRamWr, tRamAddr, tAck, tData, tTag, tErr);
    checkOutput("lo_rd_data", 64'(tData), 64'h0000_BEEF);

    // Out-of-range read and write
    doTxn(1'b1, 4'h0, 32'h0001_0000, 32'h0, 11'h005, tRamWr, tRamAddr, tAck, tData, tTag, tErr);
    checkOutput("oor_rd_err", 64'(tErr), 64'd1);
    checkOutput("oor_rd_data", 64'(tData), 64'd0);
    checkOutput("oor_rd_ack", 64'(tAck), 64'd1);
    doTxn(1'b0, 4'hF, 32'h0001_0000, 32'hDEAD_BEEF, 11'h006, tRamWr, tRamAddr, tAck, tData, tTag, tErr);
    checkOutput("oor_wr_ram_wr", 64'(tRamWr), 64'h00);
    checkOutput("oor_wr_err", 64'(tErr), 64'd1);

    // Eight reads against a stalled consumer
    @(posedge clk_i); #1;
    mem_resp_accept_i = 1'b0;
    idx = 0;
    stallAcc = 0;
    got.delete();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        @(posedge clk_i); #1;
      end
      applyStimulus(1'b1, 4'h0, 32'(idx * 4), 32'h0, 11'(idx));
      @(negedge clk_i);
      if (mem_accept_o) begin
        idx++;
        stallAcc++;
      end
    end
    checkOutput("stall_accepts", 64'(stallAcc), 64'd4);
    checkOutput("stall_accept_low", 64'(mem_accept_o), 64'd0);
    @(posedge clk_i); #1;
    mem_resp_accept_i = 1'b1;
    for (int c = 0; c < 40 && got.size() < 8; c++) begin
      if (idx < 8) applyStimulus(1'b1, 4'h0, 32'(idx * 4), 32'h0, 11'(idx));
      else applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
      @(negedge clk_i);
      if (idx < 8 && mem_accept_o) idx++;
      if (mem_ack_o) got.push_back(mem_resp_tag_o);
      @(posedge clk_i); #1;
    end
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
    checkOutput("release_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("release_order", (i < got.size()) ? 64'(got[i]) : 64'hFFFF, 64'(i));
    end

    // Streaming reads with a consumer that always takes
    accCnt = 0;
    ackCnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_i); #1;
      applyStimulus(1'b1, 4'h0, 32'(c * 8), 32'h0, 11'(16 + c));
      @(negedge clk_i);
      if (mem_accept_o) accCnt++;
      if (mem_ack_o) ackCnt++;
    end
    @(posedge clk_i); #1;
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
    checkOutput("stream_accepts", 64'(accCnt), 64'd12);
    checkOutput("stream_acks", 64'(ackCnt), 64'd10);
    repeat (4) @(posedge clk_i);

    // Reset with three responses queued
    #1;
    mem_resp_accept_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 4'h0, 32'h0000_0104, 32'h0, 11'(11'h040 + c));
      @(posedge clk_i); #1;
    end
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("queued_ack", 64'(mem_ack_o), 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("async_rst_ack", 64'(mem_ack_o), 64'd0);
    checkOutput("async_rst_accept", 64'(mem_accept_o), 64'd1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    mem_resp_accept_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      checkOutput("no_stale_ack", 64'(mem_ack_o), 64'd0);
    end

    // Normal traffic after reset, memory contents survive
    doTxn(1'b1, 4'h0, 32'h0000_0104, 32'h0, 11'h055, tRamWr, tRamAddr, tAck, tData, tTag, tErr);
    checkOutput("post_rst_data", 64'(tData), 64'h1122_3344);
    checkOutput("post_rst_tag", 64'(tTag), 64'h055);

    repeat (3) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Guards against a stuck run.
  initial begin
    #200000;
    testsFailed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
